// File: rtl/uart_rx_ctrl.sv
// Receive-path controller for uart_rx: enable sequencing on frame boundaries,
// FWFT receive FIFO, overrun/frame-error flags and character timeout.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned OVERSAMPLE_RATE = 16,
  parameter int unsigned TIMEOUT_CHARS   = 4
) (
  input  logic                            uart_clk,
  input  logic                            rst_n,
  input  logic                            sample_tick,
  input  logic                            rx_enable,
  input  logic                            fifo_flush,
  input  logic                            err_clr,
  input  logic [DATA_WIDTH-1:0]           core_data,
  input  logic                            core_valid,
  output logic                            core_ready,
  input  logic                            core_frame_error,
  input  logic                            core_rx_active,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overrun,
  output logic                            frame_err,
  output logic [7:0]                      frame_err_cnt,
  output logic                            timeout,
  output logic                            rx_enabled
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned TO_LIMIT = TIMEOUT_CHARS * 10 * OVERSAMPLE_RATE;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic [1:0] {ST_OFF, ST_ACTIVE, ST_STOPPING} state_t;

  state_t                state_q, state_d;
  logic                  ready_q;
  logic                  taken_q, taken_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic                  fe_q;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            fe_cnt_q, fe_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  timeout_q, timeout_d;

  logic accept, push, pop, full, do_push, fe_edge, to_clr;

  // taken_q blocks repeat transfers while the core holds valid across ticks.
  assign accept  = core_valid && ready_q && sample_tick && !taken_q;
  assign push    = accept && (state_q != ST_OFF);
  assign pop     = rd_valid && rd_ready;
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);
  assign fe_edge = core_frame_error && !fe_q;
  assign to_clr  = do_push || pop || fifo_flush || (level_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:      if (rx_enable && !core_rx_active) state_d = ST_ACTIVE;
      ST_ACTIVE:   if (!rx_enable) state_d = core_rx_active ? ST_STOPPING : ST_OFF;
      ST_STOPPING: begin
        if (rx_enable)                     state_d = ST_ACTIVE;
        else if (!core_rx_active && !push) state_d = ST_OFF;
      end
      default:     state_d = ST_OFF;
    endcase
  end

  always_comb begin
    taken_d = taken_q;
    if (!core_valid) taken_d = 1'b0;
    else if (accept) taken_d = 1'b1;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (fifo_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (pop)     rptr_d = rptr_q + AW'(1);
      if (do_push && !pop)      level_d = level_q + LW'(1);
      else if (!do_push && pop) level_d = level_q - LW'(1);
    end

    overrun_d = overrun_q;
    if (push && full && !pop) overrun_d = 1'b1;
    else if (err_clr)         overrun_d = 1'b0;

    frame_err_d = frame_err_q;
    fe_cnt_d    = fe_cnt_q;
    if (fe_edge) begin
      frame_err_d = 1'b1;
      if (err_clr)                fe_cnt_d = 8'd1;
      else if (fe_cnt_q != 8'hFF) fe_cnt_d = fe_cnt_q + 8'd1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
      fe_cnt_d    = '0;
    end

    to_cnt_d = to_cnt_q;
    if (to_clr)
      to_cnt_d = '0;
    else if (sample_tick && !core_rx_active && (state_q != ST_OFF) &&
             (to_cnt_q != TW'(TO_LIMIT)))
      to_cnt_d = to_cnt_q + TW'(1);
    timeout_d = !to_clr && (to_cnt_d == TW'(TO_LIMIT));
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      ready_q     <= 1'b0;
      taken_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      fe_q        <= 1'b0;
      frame_err_q <= 1'b0;
      fe_cnt_q    <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      taken_q     <= taken_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      fe_q        <= core_frame_error;
      frame_err_q <= frame_err_d;
      fe_cnt_q    <= fe_cnt_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (do_push && !fifo_flush) mem_q[wptr_q] <= core_data;
  end

  assign core_ready    = ready_q;
  assign rd_valid      = (level_q != '0);
  assign rd_data       = rd_valid ? mem_q[rptr_q] : '0;
  assign fifo_level    = level_q;
  assign overrun       = overrun_q;
  assign frame_err     = frame_err_q;
  assign frame_err_cnt = fe_cnt_q;
  assign timeout       = timeout_q;
  assign rx_enabled    = (state_q == ST_ACTIVE) || (state_q == ST_STOPPING);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with hand-computed expectations.
module tb_uart_rx_ctrl;

  logic       uart_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx_enable = 1'b0;
  logic       fifo_flush = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] core_data = '0;
  logic       core_valid = 1'b0;
  logic       core_ready;
  logic       core_frame_error = 1'b0;
  logic       core_rx_active = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] fifo_level;
  logic       overrun;
  logic       frame_err;
  logic [7:0] frame_err_cnt;
  logic       timeout;
  logic       rx_enabled;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  uart_rx_ctrl #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .OVERSAMPLE_RATE(16), .TIMEOUT_CHARS(4)
  ) dut (
    .uart_clk(uart_clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .rx_enable(rx_enable), .fifo_flush(fifo_flush), .err_clr(err_clr),
    .core_data(core_data), .core_valid(core_valid), .core_ready(core_ready),
    .core_frame_error(core_frame_error), .core_rx_active(core_rx_active),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .fifo_level(fifo_level), .overrun(overrun), .frame_err(frame_err),
    .frame_err_cnt(frame_err_cnt), .timeout(timeout), .rx_enabled(rx_enabled)
  );

  always #5 uart_clk = ~uart_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given tick value; outputs settle 1 ns after the edge.
  task automatic cyc(input logic tk);
    sample_tick = tk;
    @(posedge uart_clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    core_data  = b;
    core_valid = 1'b1;
    cyc(1'b1);
    core_valid = 1'b0;
    cyc(1'b0);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    cyc(1'b0);
    rd_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   core_ready,    0);
    check({tag, "_rdvalid"}, rd_valid,      0);
    check({tag, "_rddata"},  rd_data,       0);
    check({tag, "_level"},   fifo_level,    0);
    check({tag, "_ovr"},     overrun,       0);
    check({tag, "_ferr"},    frame_err,     0);
    check({tag, "_fcnt"},    frame_err_cnt, 0);
    check({tag, "_tmo"},     timeout,       0);
    check({tag, "_en"},      rx_enabled,    0);
  endtask

  initial begin
    cyc(1'b0);
    cyc(1'b0);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(1'b0);
    check("ready_after_reset", core_ready, 1);
    check("off_after_reset", rx_enabled, 0);

    // Enable, then one byte with valid held across three ticks.
    rx_enable = 1'b1;
    cyc(1'b0);
    check("enabled", rx_enabled, 1);
    core_data  = 8'hA5;
    core_valid = 1'b1;
    for (int i = 0; i < 40; i++) cyc((i % 13) == 5);
    core_valid = 1'b0;
    cyc(1'b0);
    check("single_push_level", fifo_level, 1);
    check("single_push_data", rd_data, 8'hA5);
    pop_one();
    check("pop_level", fifo_level, 0);

    // Overfill by one.
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("full_level", fifo_level, 16);
    check("no_ovr_yet", overrun, 0);
    send_byte(8'h10);
    check("ovr_level", fifo_level, 16);
    check("ovr_set", overrun, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), rd_data, i);
      pop_one();
    end
    check("drained", fifo_level, 0);
    check("drained_valid", rd_valid, 0);
    err_clr = 1'b1;
    cyc(1'b0);
    err_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
    core_data  = 8'h55;
    core_valid = 1'b1;
    rd_ready   = 1'b1;
    cyc(1'b1);
    core_valid = 1'b0;
    rd_ready   = 1'b0;
    cyc(1'b0);
    check("pp_full_level", fifo_level, 16);
    check("pp_full_ovr", overrun, 0);
    check("pp_head", rd_data, 8'h21);
    for (int i = 0; i < 15; i++) pop_one();
    check("pp_last", rd_data, 8'h55);
    pop_one();
    check("pp_empty", fifo_level, 0);

    // Character timeout: 4 * 10 * 16 = 640 ticks after the push.
    send_byte(8'h11);
    repeat (639) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    check("tmo_before", timeout, 0);
    cyc(1'b1);
    check("tmo_at_640", timeout, 1);
    pop_one();
    check("tmo_pop_clr", timeout, 0);

    // Flush overrides a same-cycle push.
    send_byte(8'h01);
    send_byte(8'h02);
    core_data  = 8'h03;
    core_valid = 1'b1;
    fifo_flush = 1'b1;
    cyc(1'b1);
    fifo_flush = 1'b0;
    core_valid = 1'b0;
    cyc(1'b0);
    check("flush_level", fifo_level, 0);

    // Disable mid-frame: in-flight byte stored, then OFF.
    core_rx_active = 1'b1;
    rx_enable      = 1'b0;
    cyc(1'b0);
    check("stopping_en", rx_enabled, 1);
    core_data      = 8'h3C;
    core_valid     = 1'b1;
    core_rx_active = 1'b0;
    cyc(1'b1);
    core_valid = 1'b0;
    check("stop_xfer_en", rx_enabled, 1);
    cyc(1'b0);
    check("stop_off", rx_enabled, 0);
    check("stop_level", fifo_level, 1);
    check("stop_data", rd_data, 8'h3C);
    send_byte(8'h77);
    check("off_discard_level", fifo_level, 1);
    check("off_discard_data", rd_data, 8'h3C);
    pop_one();

    // Frame errors.
    rx_enable = 1'b1;
    cyc(1'b0);
    repeat (3) begin
      core_frame_error = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      core_frame_error = 1'b0;
      cyc(1'b0);
    end
    cyc(1'b0);
    check("ferr_cnt3", frame_err_cnt, 3);
    check("ferr_flag", frame_err, 1);
    err_clr = 1'b1;
    cyc(1'b0);
    err_clr = 1'b0;
    check("ferr_clr_cnt", frame_err_cnt, 0);
    check("ferr_clr_flag", frame_err, 0);
    core_frame_error = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    core_frame_error = 1'b0;
    cyc(1'b0);
    check("ferr_again", frame_err_cnt, 1);
    core_frame_error = 1'b1;
    err_clr          = 1'b1;
    cyc(1'b0);
    core_frame_error = 1'b0;
    err_clr          = 1'b0;
    cyc(1'b0);
    check("ferr_wins_cnt", frame_err_cnt, 1);
    check("ferr_wins_flag", frame_err, 1);

    // Reset mid-frame with five bytes stored.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
    check("pre_rst_level", fifo_level, 5);
    core_rx_active = 1'b1;
    rst_n = 1'b0;
    cyc(1'b0);
    check_all_zero("midrst");
    rst_n = 1'b1;
    core_rx_active = 1'b0;
    rx_enable = 1'b0;
    cyc(1'b0);
    check("post_rst_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
